ysyx_24090012_mem_arbiter: RTL
==============================

// Module: ysyx_24090012_mem_arbiter
// PURPOSE
//  Arbitrates the single AXI4 io_master port between the IFU (read-only, 4-beat INCR bursts)
//  and the LSU (single-beat reads and writes). Grants one whole transaction at a time, then
//  routes R/B responses back to the owner. Sits between the IFU/LSU and the SoC crossbar.
//  Keeps per-requester grant counters and a conflict counter for performance analysis.
// PARAMETERS
//  CNT_W   32  width of the performance counters
// PORTS
//  clock                      in   1   system clock
//  reset                      in   1   asynchronous, active-high reset
//  ifu_ar{valid,ready}        in/out 1 IFU AR handshake; ifu_ar{addr 32,id 4,len 8,size 3,burst 2} in
//  ifu_r{valid,ready}         out/in 1 IFU R handshake; ifu_r{data 32,id 4,last 1,resp 2} out
//  lsu_ar{valid,ready}        in/out 1 LSU AR handshake; lsu_ar{addr 32,id 4,len 8,size 3,burst 2} in
//  lsu_r{valid,ready}         out/in 1 LSU R handshake; lsu_r{data 32,id 4,last 1,resp 2} out
//  lsu_aw{valid,ready}        in/out 1 LSU AW handshake; lsu_aw{addr 32,id 4,len 8,size 3,burst 2} in
//  lsu_w{valid,ready}         in/out 1 LSU W handshake; lsu_w{data 32,strb 4,last 1} in
//  lsu_b{valid,ready}         out/in 1 LSU B handshake; lsu_b{id 4,resp 2} out
//  io_master_{ar,r,aw,w,b}*   mixed   downstream AXI4 master, same widths as the LSU channels
//  ifu_grant_cnt, lsu_grant_cnt, conflict_cnt  out CNT_W  performance counters
// BEHAVIOUR
//  - States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP; owner reg (0=IFU,1=LSU); last_owner reg.
//  - Reset: state=IDLE, owner=0, last_owner=1 (IFU wins first tie); counters=0; all
//    outgoing valid/ready=0. Reset mid-transaction aborts it; no pending response is replayed.
//  - IDLE: requests are ifu_arvalid, lsu_arvalid, lsu_awvalid (LSU AR and AW never asserted together).
//    One requester -> grant it. IFU and LSU both -> grant the one not equal to last_owner, conflict_cnt++.
//    Grant takes 1 cycle: IDLE->RD_ADDR or WR_ADDR; no channel is forwarded in IDLE.
//  - RD_ADDR: mux owner's AR onto io_master_ar*, arready back to owner only; handshake -> RD_DATA.
//  - RD_DATA: io_master_r* fanned to owner only, io_master_rready = owner's rready; other requester's
//    rvalid=0. Beat with rvalid&rready&rlast -> IDLE, last_owner=owner, owner's grant_cnt++.
//  - WR_ADDR: lsu_aw* -> io_master_aw*; handshake -> WR_DATA. WR_DATA: lsu_w* -> io_master_w*;
//    handshake with wlast -> WR_RESP. WR_RESP: io_master_b* -> lsu_b*; handshake -> IDLE, lsu_grant_cnt++.
//  - AR/AW/W outputs are combinational muxes of the owner's inputs; valid deasserted outside the
//    matching state. Address/attributes must stay stable while valid (the owner guarantees this).
//  - rresp/bresp passed through unmodified; SLVERR/DECERR do not change sequencing.
//  - One outstanding transaction total; IFU stays stalled for the whole LSU transaction and vice versa.
//  - Counters wrap modulo 2^CNT_W without saturation.
//  - Same-cycle rlast handshake and new request: the new request is granted on the next
//    cycle from IDLE (min 1 idle cycle between transactions).
// STRUCTURE
//  - Shared package: state encoding localparams, AXI burst/size/resp constants.
//  - Sub-module ysyx_24090012_rr_arb2: 2-way round-robin picker (req[1:0], last, grant[1:0]).
//  - Remainder is FSM + channel muxes + counters in this module.
// TESTING
//  1. IFU alone: AR addr 0x3000_0000 len 3, 4 R beats -> ifu_r sees 4 beats, rlast on 4th; ifu_grant_cnt=1.
//  2. Same-cycle IFU AR and LSU AR after reset -> IFU served first, LSU next; conflict_cnt=1,
//     lsu_arready stays 0 until IFU rlast accepted.
//  3. LSU write 0x8000_0010 data 0xDEADBEEF strb 0xF -> AW, W, B in order; lsu_bresp=0; lsu_grant_cnt=1.
//  4. Back-to-back contention, 3 rounds -> grants alternate IFU,LSU,IFU,...; conflict_cnt=3.
//  5. Backpressure: ifu_rready low 5 cycles mid-burst -> io_master_rready low, no beat lost or duplicated.
//  6. Assert reset during RD_DATA -> next cycle all valids 0, state IDLE, counters 0.

Source files
------------

// File: rtl/ysyx_24090012_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24090012_mem_arbiter_pkg
// Description : Shared state encoding, owner IDs and AXI4 field constants
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24090012_mem_arbiter_pkg;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_ADDR = 3'd1;
    localparam logic [2:0] c_ST_RD_DATA = 3'd2;
    localparam logic [2:0] c_ST_WR_ADDR = 3'd3;
    localparam logic [2:0] c_ST_WR_DATA = 3'd4;
    localparam logic [2:0] c_ST_WR_RESP = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_RD_ADDR = c_ST_RD_ADDR,
        ST_RD_DATA = c_ST_RD_DATA,
        ST_WR_ADDR = c_ST_WR_ADDR,
        ST_WR_DATA = c_ST_WR_DATA,
        ST_WR_RESP = c_ST_WR_RESP
    } arb_state_t;

    localparam logic c_OWNER_IFU = 1'b0;
    localparam logic c_OWNER_LSU = 1'b1;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [2:0] c_SIZE_BYTE = 3'b000;
    localparam logic [2:0] c_SIZE_HALF = 3'b001;
    localparam logic [2:0] c_SIZE_WORD = 3'b010;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/ysyx_24090012_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24090012_rr_arb2
// Description : 2-way round-robin picker; bit 0 = IFU, bit 1 = LSU
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24090012_rr_arb2
    import ysyx_24090012_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == c_OWNER_LSU) ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_24090012_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24090012_mem_arbiter
// Description : Whole-transaction AXI4 arbiter between IFU and LSU onto io_master
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24090012_mem_arbiter
    import ysyx_24090012_mem_arbiter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ifu_arvalid,
    output logic             ifu_arready,
    input  logic [31:0]      ifu_araddr,
    input  logic [3:0]       ifu_arid,
    input  logic [7:0]       ifu_arlen,
    input  logic [2:0]       ifu_arsize,
    input  logic [1:0]       ifu_arburst,
    output logic             ifu_rvalid,
    input  logic             ifu_rready,
    output logic [31:0]      ifu_rdata,
    output logic [3:0]       ifu_rid,
    output logic             ifu_rlast,
    output logic [1:0]       ifu_rresp,
    input  logic             lsu_arvalid,
    output logic             lsu_arready,
    input  logic [31:0]      lsu_araddr,
    input  logic [3:0]       lsu_arid,
    input  logic [7:0]       lsu_arlen,
    input  logic [2:0]       lsu_arsize,
    input  logic [1:0]       lsu_arburst,
    output logic             lsu_rvalid,
    input  logic             lsu_rready,
    output logic [31:0]      lsu_rdata,
    output logic [3:0]       lsu_rid,
    output logic             lsu_rlast,
    output logic [1:0]       lsu_rresp,
    input  logic             lsu_awvalid,
    output logic             lsu_awready,
    input  logic [31:0]      lsu_awaddr,
    input  logic [3:0]       lsu_awid,
    input  logic [7:0]       lsu_awlen,
    input  logic [2:0]       lsu_awsize,
    input  logic [1:0]       lsu_awburst,
    input  logic             lsu_wvalid,
    output logic             lsu_wready,
    input  logic [31:0]      lsu_wdata,
    input  logic [3:0]       lsu_wstrb,
    input  logic             lsu_wlast,
    output logic             lsu_bvalid,
    input  logic             lsu_bready,
    output logic [3:0]       lsu_bid,
    output logic [1:0]       lsu_bresp,
    output logic             io_master_arvalid,
    input  logic             io_master_arready,
    output logic [31:0]      io_master_araddr,
    output logic [3:0]       io_master_arid,
    output logic [7:0]       io_master_arlen,
    output logic [2:0]       io_master_arsize,
    output logic [1:0]       io_master_arburst,
    input  logic             io_master_rvalid,
    output logic             io_master_rready,
    input  logic [31:0]      io_master_rdata,
    input  logic [3:0]       io_master_rid,
    input  logic             io_master_rlast,
    input  logic [1:0]       io_master_rresp,
    output logic             io_master_awvalid,
    input  logic             io_master_awready,
    output logic [31:0]      io_master_awaddr,
    output logic [3:0]       io_master_awid,
    output logic [7:0]       io_master_awlen,
    output logic [2:0]       io_master_awsize,
    output logic [1:0]       io_master_awburst,
    output logic             io_master_wvalid,
    input  logic             io_master_wready,
    output logic [31:0]      io_master_wdata,
    output logic [3:0]       io_master_wstrb,
    output logic             io_master_wlast,
    input  logic             io_master_bvalid,
    output logic             io_master_bready,
    input  logic [3:0]       io_master_bid,
    input  logic [1:0]       io_master_bresp,
    output logic [CNT_W-1:0] ifu_grant_cnt,
    output logic [CNT_W-1:0] lsu_grant_cnt,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic             r_owner;
    logic             r_last_owner;
    logic [CNT_W-1:0] r_ifu_grant_cnt;
    logic [CNT_W-1:0] r_lsu_grant_cnt;
    logic [CNT_W-1:0] r_conflict_cnt;

    logic       w_ifu_req;
    logic       w_lsu_req;
    logic [1:0] w_grant;
    logic       w_is_lsu;
    logic       w_conflict;
    logic       w_rd_done;
    logic       w_wr_done;

    assign w_ifu_req  = ifu_arvalid;
    assign w_lsu_req  = lsu_arvalid | lsu_awvalid;
    assign w_is_lsu   = (r_owner == c_OWNER_LSU);
    assign w_conflict = (r_state == ST_IDLE) && w_ifu_req && w_lsu_req;

    ysyx_24090012_rr_arb2 u_rr_arb2 (
        .req   ({w_lsu_req, w_ifu_req}),
        .last  (r_last_owner),
        .grant (w_grant)
    );

    // Payload fields are always muxed; only the valid/ready pairs are state-gated.
    assign io_master_araddr  = w_is_lsu ? lsu_araddr  : ifu_araddr;
    assign io_master_arid    = w_is_lsu ? lsu_arid    : ifu_arid;
    assign io_master_arlen   = w_is_lsu ? lsu_arlen   : ifu_arlen;
    assign io_master_arsize  = w_is_lsu ? lsu_arsize  : ifu_arsize;
    assign io_master_arburst = w_is_lsu ? lsu_arburst : ifu_arburst;

    assign io_master_awaddr  = lsu_awaddr;
    assign io_master_awid    = lsu_awid;
    assign io_master_awlen   = lsu_awlen;
    assign io_master_awsize  = lsu_awsize;
    assign io_master_awburst = lsu_awburst;
    assign io_master_wdata   = lsu_wdata;
    assign io_master_wstrb   = lsu_wstrb;
    assign io_master_wlast   = lsu_wlast;

    assign ifu_rdata = io_master_rdata;
    assign ifu_rid   = io_master_rid;
    assign ifu_rlast = io_master_rlast;
    assign ifu_rresp = io_master_rresp;
    assign lsu_rdata = io_master_rdata;
    assign lsu_rid   = io_master_rid;
    assign lsu_rlast = io_master_rlast;
    assign lsu_rresp = io_master_rresp;
    assign lsu_bid   = io_master_bid;
    assign lsu_bresp = io_master_bresp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_rd_done         = 1'b0;
        w_wr_done         = 1'b0;
        io_master_arvalid = 1'b0;
        ifu_arready       = 1'b0;
        lsu_arready       = 1'b0;
        io_master_rready  = 1'b0;
        ifu_rvalid        = 1'b0;
        lsu_rvalid        = 1'b0;
        io_master_awvalid = 1'b0;
        lsu_awready       = 1'b0;
        io_master_wvalid  = 1'b0;
        lsu_wready        = 1'b0;
        io_master_bready  = 1'b0;
        lsu_bvalid        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant != 2'b00) begin
                    w_state_next = (w_grant[1] && lsu_awvalid) ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                io_master_arvalid = w_is_lsu ? lsu_arvalid : ifu_arvalid;
                if (w_is_lsu) begin
                    lsu_arready = io_master_arready;
                end else begin
                    ifu_arready = io_master_arready;
                end
                if (io_master_arvalid && io_master_arready) begin
                    w_state_next = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                io_master_rready = w_is_lsu ? lsu_rready : ifu_rready;
                if (w_is_lsu) begin
                    lsu_rvalid = io_master_rvalid;
                end else begin
                    ifu_rvalid = io_master_rvalid;
                end
                if (io_master_rvalid && io_master_rready && io_master_rlast) begin
                    w_rd_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                io_master_awvalid = lsu_awvalid;
                lsu_awready       = io_master_awready;
                if (lsu_awvalid && io_master_awready) begin
                    w_state_next = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                io_master_wvalid = lsu_wvalid;
                lsu_wready       = io_master_wready;
                if (lsu_wvalid && io_master_wready && lsu_wlast) begin
                    w_state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                lsu_bvalid       = io_master_bvalid;
                io_master_bready = lsu_bready;
                if (io_master_bvalid && lsu_bready) begin
                    w_wr_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Ownership and statistics; counters wrap freely.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner         <= c_OWNER_IFU;
            r_last_owner    <= c_OWNER_LSU;
            r_ifu_grant_cnt <= '0;
            r_lsu_grant_cnt <= '0;
            r_conflict_cnt  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (w_grant != 2'b00)) begin
                r_owner <= w_grant[1];
            end
            if (w_rd_done) begin
                r_last_owner <= r_owner;
                if (w_is_lsu) begin
                    r_lsu_grant_cnt <= r_lsu_grant_cnt + c_CNT_ONE;
                end else begin
                    r_ifu_grant_cnt <= r_ifu_grant_cnt + c_CNT_ONE;
                end
            end
            if (w_wr_done) begin
                r_last_owner    <= c_OWNER_LSU;
                r_lsu_grant_cnt <= r_lsu_grant_cnt + c_CNT_ONE;
            end
            if (w_conflict) begin
                r_conflict_cnt <= r_conflict_cnt + c_CNT_ONE;
            end
        end
    end

    assign ifu_grant_cnt = r_ifu_grant_cnt;
    assign lsu_grant_cnt = r_lsu_grant_cnt;
    assign conflict_cnt  = r_conflict_cnt;

endmodule
`default_nettype wire
